// File: rtl/sim_exit_reporter_if.sv
// tohost write channel between a DUT and the harness exit reporter.
// Single-beat valid/ready transfer carrying the DATA_W-bit tohost payload.
interface sim_exit_reporter_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] bits;

  modport master (
    output valid,
    output bits,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits,
    output ready
  );
endinterface

// File: rtl/sim_exit_reporter.sv
// Sinks the DUT tohost stream, decodes the exit protocol and drives sticky success/failure levels.
// Optional idle watchdog is compiled in when SIM_EXIT_WATCHDOG_EN is defined.
module sim_exit_reporter #(
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned DRAIN_CYCLES    = 16,
  parameter int unsigned WATCHDOG_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  sim_exit_reporter_if.slave   tohost,
  input  logic                 heartbeat,
  output logic                 success,
  output logic                 failure,
  output logic [DATA_W-2:0]    exit_code,
  output logic [31:0]          msg_count
);

  typedef enum logic [1:0] {StRun, StDrain, StPass, StFail} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              success_q, success_d;
  logic              failure_q, failure_d;
  logic [DATA_W-2:0] exit_code_q, exit_code_d;
  logic [31:0]       msg_count_q, msg_count_d;
  logic [31:0]       drain_q, drain_d;

  logic              accept;
  logic              wd_expire;
  logic [DATA_W-2:0] code;

  assign accept      = tohost.valid && ready_q;
  assign code        = tohost.bits[DATA_W-1:1];
  assign tohost.ready = ready_q;

`ifdef SIM_EXIT_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_inc;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_inc   = 1'b0;
    if (state_q == StRun && WATCHDOG_CYCLES != 0) begin
      if (heartbeat || accept) begin
        wd_cnt_d = '0;
      end else begin
        wd_inc = 1'b1;
        if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
  end

  // Fires on the increment that brings the count to WATCHDOG_CYCLES-1.
  assign wd_expire = wd_inc &&
                     ((33'(wd_cnt_q) + 33'd1) >= (33'(WATCHDOG_CYCLES) - 33'd1));

  always_ff @(posedge clock) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  localparam int unsigned unused_wd_cycles = WATCHDOG_CYCLES;
  logic unused_heartbeat;
  assign unused_heartbeat = heartbeat;
  assign wd_expire        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    exit_code_d = exit_code_q;
    msg_count_d = msg_count_q;
    case (state_q)
      StRun: begin
        // An accepted beat always takes priority over a same-cycle watchdog expiry.
        if (accept) begin
          if (!tohost.bits[0]) begin
            if (tohost.bits != '0) msg_count_d = msg_count_q + 32'd1;
          end else if (code == '0) begin
            exit_code_d = '0;
            if (DRAIN_CYCLES == 0) begin
              state_d = StPass;
            end else begin
              state_d = StDrain;
              drain_d = DRAIN_CYCLES;
            end
          end else begin
            exit_code_d = code;
            state_d     = StFail;
          end
        end else if (wd_expire) begin
          exit_code_d = '1;
          state_d     = StFail;
        end
      end
      StDrain: begin
        drain_d = drain_q - 32'd1;
        if (drain_q == 32'd1) state_d = StPass;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    ready_d   = (state_d == StRun);
    success_d = success_q || (state_q == StPass);
    failure_d = failure_q || (state_q == StFail);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StRun;
      ready_q     <= 1'b1;
      success_q   <= 1'b0;
      failure_q   <= 1'b0;
      exit_code_q <= '0;
      msg_count_q <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      success_q   <= success_d;
      failure_q   <= failure_d;
      exit_code_q <= exit_code_d;
      msg_count_q <= msg_count_d;
      drain_q     <= drain_d;
    end
  end

  assign success   = success_q;
  assign failure   = failure_q;
  assign exit_code = exit_code_q;
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_sim_exit_reporter.sv
// Scoreboard bench for sim_exit_reporter: one instance with a 16-cycle drain, one with no drain.
// Watchdog expectations follow SIM_EXIT_WATCHDOG_EN.
module tb_sim_exit_reporter;

  typedef struct {
    bit          is_pass;
    int          cyc;
    logic [62:0] code;
    logic [31:0] msgs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hb_a = 1'b0;
  logic        hb_b = 1'b0;
  logic        succ_a, fail_a, succ_b, fail_b;
  logic [62:0] code_a, code_b;
  logic [31:0] msg_a, msg_b;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic        ps_a = 1'b0, pf_a = 1'b0, ps_b = 1'b0, pf_b = 1'b0;

  sim_exit_reporter_if #(.DATA_W(64)) if_a ();
  sim_exit_reporter_if #(.DATA_W(64)) if_b ();

  sim_exit_reporter #(.DATA_W(64), .DRAIN_CYCLES(16), .WATCHDOG_CYCLES(50)) dut_a (
    .clock(clk), .reset(rst), .tohost(if_a.slave), .heartbeat(hb_a),
    .success(succ_a), .failure(fail_a), .exit_code(code_a), .msg_count(msg_a)
  );

  sim_exit_reporter #(.DATA_W(64), .DRAIN_CYCLES(0), .WATCHDOG_CYCLES(0)) dut_b (
    .clock(clk), .reset(rst), .tohost(if_b.slave), .heartbeat(hb_b),
    .success(succ_b), .failure(fail_b), .exit_code(code_b), .msg_count(msg_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input string tag, input bit have, input exp_t e, input logic s,
                       input logic f, input logic [62:0] c, input logic [31:0] m);
    if (!have) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_exit: success=%0b failure=%0b with nothing expected (cycle %0d)",
               tag, s, f, cyc);
    end else begin
      check({tag, "_kind_success"}, 64'(s), 64'(e.is_pass));
      check({tag, "_kind_failure"}, 64'(f), 64'(!e.is_pass));
      check({tag, "_exit_cycle"}, 64'(cyc), 64'(e.cyc));
      check({tag, "_exit_code"}, 64'(c), 64'(e.code));
      check({tag, "_msg_count"}, 64'(m), 64'(e.msgs));
    end
  endtask

  // Monitor: every rising success/failure must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      if ((succ_a && !ps_a) || (fail_a && !pf_a)) begin
        have = (qa.size() > 0);
        if (have) e = qa.pop_front();
        score("a", have, e, succ_a, fail_a, code_a, msg_a);
      end
      if ((succ_b && !ps_b) || (fail_b && !pf_b)) begin
        have = (qb.size() > 0);
        if (have) e = qb.pop_front();
        score("b", have, e, succ_b, fail_b, code_b, msg_b);
      end
    end
    ps_a = succ_a;
    pf_a = fail_a;
    ps_b = succ_b;
    pf_b = fail_b;
  end

  task automatic send(input bit to_b, input logic [63:0] b, output int acc);
    if (to_b) begin
      if_b.valid = 1'b1;
      if_b.bits  = b;
    end else begin
      if_a.valid = 1'b1;
      if_a.bits  = b;
    end
    @(posedge clk);
    #1;
    acc        = cyc;
    if_a.valid = 1'b0;
    if_b.valid = 1'b0;
  endtask

  task automatic do_reset(output int rel);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int rel;
    if_a.valid = 1'b0;
    if_a.bits  = '0;
    if_b.valid = 1'b0;
    if_b.bits  = '0;

    // Reset values
    do_reset(rel);
    check("rst_ready", 64'(if_a.ready), 64'd1);
    check("rst_success", 64'(succ_a), 64'd0);
    check("rst_failure", 64'(fail_a), 64'd0);
    check("rst_exit_code", 64'(code_a), 64'd0);
    check("rst_msg_count", 64'(msg_a), 64'd0);

    // Pass exit with 16-cycle drain
    send(1'b0, 64'h1, acc);
    qa.push_back('{is_pass: 1'b1, cyc: acc + 17, code: 63'd0, msgs: 32'd0});
    check("pass_ready_low", 64'(if_a.ready), 64'd0);
    idle(30);
    check("pass_no_failure", 64'(fail_a), 64'd0);

    // Fail exit, code 3
    do_reset(rel);
    send(1'b0, 64'h7, acc);
    qa.push_back('{is_pass: 1'b0, cyc: acc + 1, code: 63'd3, msgs: 32'd0});
    idle(1000);
    check("fail_no_success", 64'(succ_a), 64'd0);
    check("fail_sticky", 64'(fail_a), 64'd1);
    check("fail_code_held", 64'(code_a), 64'd3);

    // Messages then pass, on both drain settings
    do_reset(rel);
    send(1'b0, 64'h2, acc);
    send(1'b0, 64'h0, acc);
    send(1'b0, 64'h4, acc);
    check("msg_count_two", 64'(msg_a), 64'd2);
    send(1'b0, 64'h1, acc);
    qa.push_back('{is_pass: 1'b1, cyc: acc + 17, code: 63'd0, msgs: 32'd2});
    send(1'b1, 64'h2, acc);
    send(1'b1, 64'h4, acc);
    send(1'b1, 64'h1, acc);
    qb.push_back('{is_pass: 1'b1, cyc: acc + 1, code: 63'd0, msgs: 32'd2});
    idle(20);

    // Stalled valid in PASS has no side effects
    if_a.valid = 1'b1;
    if_a.bits  = 64'h6;
    idle(10);
    check("stall_ready_low", 64'(if_a.ready), 64'd0);
    check("stall_msg_count", 64'(msg_a), 64'd2);
    check("stall_exit_code", 64'(code_a), 64'd0);
    if_a.valid = 1'b0;

    // Reset mid-drain, then a failing exit
    do_reset(rel);
    send(1'b0, 64'h1, acc);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_success", 64'(succ_a), 64'd0);
    check("mid_rst_ready", 64'(if_a.ready), 64'd1);
    check("mid_rst_msg_count", 64'(msg_a), 64'd0);
    idle(25);
    check("mid_rst_no_late_success", 64'(succ_a), 64'd0);
    send(1'b0, 64'h5, acc);
    qa.push_back('{is_pass: 1'b0, cyc: acc + 1, code: 63'd2, msgs: 32'd0});
    idle(5);

    // Idle with no heartbeat
    do_reset(rel);
`ifdef SIM_EXIT_WATCHDOG_EN
    qa.push_back('{is_pass: 1'b0, cyc: rel + 50, code: {63{1'b1}}, msgs: 32'd0});
    idle(60);
    check("wd_fired", 64'(fail_a), 64'd1);
`else
    idle(10000);
    check("wd_off_no_fail", 64'(fail_a), 64'd0);
`endif

    // Heartbeat every 40 cycles keeps the watchdog quiet
    do_reset(rel);
    for (int i = 0; i < 8; i++) begin
      idle(39);
      hb_a = 1'b1;
      idle(1);
      hb_a = 1'b0;
    end
    check("hb_no_fail", 64'(fail_a), 64'd0);

    // Accept on the expiry edge wins over the watchdog
    do_reset(rel);
    idle(48);
    send(1'b0, 64'h2, acc);
    check("expiry_accept_edge", 64'(acc), 64'(rel + 49));
    idle(5);
    check("expiry_accept_no_fail", 64'(fail_a), 64'd0);
    check("expiry_accept_msg", 64'(msg_a), 64'd1);

    rst = 1'b1;
    idle(2);
    check("scoreboard_a_drained", 64'(qa.size()), 64'd0);
    check("scoreboard_b_drained", 64'(qb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
